// File: rtl/endgame_controller.sv
// Game end-state controller: tracks lives, decides WIN/LOSS and gates restart behind an end-screen hold.
// Optional per-game frame time limit is compiled in with `define ENDGAME_TIMEOUT_EN.
module endgame_controller #(
    parameter int unsigned LIVES_INIT        = 3,
    parameter int unsigned HOLD_FRAMES       = 180,
    parameter int unsigned TIME_LIMIT_FRAMES = 3600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_of_frame,
    input  logic       game_start,
    input  logic       player_hit,
    input  logic       level_cleared,
    input  logic       restart_req,
    output logic       is_win,
    output logic       is_loss,
    output logic       game_active,
    output logic [1:0] lives,
    output logic       game_over
);

    typedef enum logic [1:0] {StIdle, StPlaying, StWin, StLoss} state_e;

    localparam logic [1:0] LivesInit = 2'(LIVES_INIT);
    localparam logic [7:0] HoldMax   = 8'(HOLD_FRAMES);

    state_e     state_q, state_d;
    logic [1:0] lives_q, lives_d;
    logic [7:0] hold_q, hold_d;
    logic       is_win_q, is_win_d;
    logic       is_loss_q, is_loss_d;
    logic       game_active_q, game_active_d;
    logic       game_over_q, game_over_d;

`ifdef ENDGAME_TIMEOUT_EN
    localparam logic [15:0] TimeLimit = 16'(TIME_LIMIT_FRAMES);

    logic [15:0] timer_q, timer_d;
    logic        time_up;

    always_comb begin
        timer_d = timer_q;
        if (state_q == StIdle && game_start) begin
            timer_d = '0;
        end else if (state_q == StPlaying && start_of_frame) begin
            timer_d = timer_q + 16'd1;
        end
        time_up = (state_q == StPlaying) && start_of_frame && (timer_d >= TimeLimit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        hold_d  = hold_q;
        unique case (state_q)
            StIdle: begin
                if (game_start) begin
                    state_d = StPlaying;
                    lives_d = LivesInit;
                end
            end
            StPlaying: begin
                // Win beats every loss cause in the same cycle, and leaves lives untouched.
                if (level_cleared) begin
                    state_d = StWin;
`ifdef ENDGAME_TIMEOUT_EN
                end else if (time_up) begin
                    state_d = StLoss;
`endif
                end else if (player_hit) begin
                    if (lives_q > 2'd1) begin
                        lives_d = lives_q - 2'd1;
                    end else begin
                        lives_d = 2'd0;
                        state_d = StLoss;
                    end
                end
                if (state_d != StPlaying) begin
                    hold_d = '0;
                end
            end
            StWin, StLoss: begin
                // Early restart requests are simply dropped.
                if (restart_req && hold_q == HoldMax) begin
                    state_d = StIdle;
                end else if (start_of_frame && hold_q != HoldMax) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        is_win_d      = (state_d == StWin);
        is_loss_d     = (state_d == StLoss);
        game_active_d = (state_d == StPlaying);
        game_over_d   = (state_q == StPlaying) && (state_d == StWin || state_d == StLoss);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            lives_q       <= '0;
            hold_q        <= '0;
            is_win_q      <= 1'b0;
            is_loss_q     <= 1'b0;
            game_active_q <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            hold_q        <= hold_d;
            is_win_q      <= is_win_d;
            is_loss_q     <= is_loss_d;
            game_active_q <= game_active_d;
            game_over_q   <= game_over_d;
        end
    end

    assign is_win      = is_win_q;
    assign is_loss     = is_loss_q;
    assign game_active = game_active_q;
    assign lives       = lives_q;
    assign game_over   = game_over_q;

endmodule

// File: tb/tb_endgame_controller.sv
// Directed bench for endgame_controller; output word is {is_win, is_loss, game_active, game_over, lives}.
// Timeout expectations follow ENDGAME_TIMEOUT_EN when the bench is built with it.
module tb_endgame_controller;

    logic       clk;
    logic       rst_n;
    logic       start_of_frame;
    logic       game_start;
    logic       player_hit;
    logic       level_cleared;
    logic       restart_req;
    logic       is_win;
    logic       is_loss;
    logic       game_active;
    logic [1:0] lives;
    logic       game_over;

    int total;
    int bad;

    endgame_controller #(
        .LIVES_INIT       (3),
        .HOLD_FRAMES      (4),
        .TIME_LIMIT_FRAMES(10)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_of_frame(start_of_frame),
        .game_start    (game_start),
        .player_hit    (player_hit),
        .level_cleared (level_cleared),
        .restart_req   (restart_req),
        .is_win        (is_win),
        .is_loss       (is_loss),
        .game_active   (game_active),
        .lives         (lives),
        .game_over     (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] exp_out(input logic w, input logic l, input logic a,
                                           input logic g, input logic [1:0] lv);
        return {w, l, a, g, lv};
    endfunction

    task automatic check(input string tag, input logic [5:0] expected);
        logic [5:0] observed;
        observed = {is_win, is_loss, game_active, game_over, lives};
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Drive a one-cycle pulse set, then sample 1 ns after the edge that consumed it.
    task automatic step(input logic sof, input logic gs, input logic ph, input logic lc,
                        input logic rr);
        start_of_frame = sof;
        game_start     = gs;
        player_hit     = ph;
        level_cleared  = lc;
        restart_req    = rr;
        @(posedge clk);
        #1;
        start_of_frame = 1'b0;
        game_start     = 1'b0;
        player_hit     = 1'b0;
        level_cleared  = 1'b0;
        restart_req    = 1'b0;
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst_n          = 1'b1;
        start_of_frame = 1'b0;
        game_start     = 1'b0;
        player_hit     = 1'b0;
        level_cleared  = 1'b0;
        restart_req    = 1'b0;

        #2 rst_n = 1'b0;
        #2 check("reset_outputs", exp_out(0, 0, 0, 0, 2'd0));
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(0, 0, 0, 0, 0);
        check("idle_after_reset", exp_out(0, 0, 0, 0, 2'd0));

        // Lose all lives
        step(0, 1, 0, 0, 0);
        check("start_lives3", exp_out(0, 0, 1, 0, 2'd3));
        step(0, 0, 1, 0, 0);
        check("hit1_lives2", exp_out(0, 0, 1, 0, 2'd2));
        step(0, 0, 1, 0, 0);
        check("hit2_lives1", exp_out(0, 0, 1, 0, 2'd1));
        step(0, 0, 1, 0, 0);
        check("hit3_loss_go", exp_out(0, 1, 0, 1, 2'd0));
        step(0, 0, 0, 0, 0);
        check("loss_go_drops", exp_out(0, 1, 0, 0, 2'd0));
        step(0, 1, 0, 0, 0);
        check("loss_ignores_start", exp_out(0, 1, 0, 0, 2'd0));
        step(0, 0, 1, 1, 0);
        check("loss_ignores_events", exp_out(0, 1, 0, 0, 2'd0));
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check("loss_restart_idle", exp_out(0, 0, 0, 0, 2'd0));

        // Simultaneous clear and hit, then hold-gated restart
        step(0, 1, 0, 0, 0);
        check("start_again", exp_out(0, 0, 1, 0, 2'd3));
        step(0, 0, 1, 1, 0);
        check("clear_and_hit_win", exp_out(1, 0, 0, 1, 2'd3));
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check("early_restart_dropped", exp_out(1, 0, 0, 0, 2'd3));
        step(0, 0, 1, 1, 0);
        check("win_ignores_events", exp_out(1, 0, 0, 0, 2'd3));
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("hold3_still_win", exp_out(1, 0, 0, 0, 2'd3));
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check("hold4_restart_idle", exp_out(0, 0, 0, 0, 2'd3));
        step(0, 0, 1, 1, 1);
        check("idle_ignores_events", exp_out(0, 0, 0, 0, 2'd3));

        // Frame time limit
        step(0, 1, 0, 0, 0);
        check("timer_game_start", exp_out(0, 0, 1, 0, 2'd3));
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0);
        check("nine_frames_active", exp_out(0, 0, 1, 0, 2'd3));
        step(1, 0, 0, 0, 0);
`ifdef ENDGAME_TIMEOUT_EN
        check("ten_frames_timeout", exp_out(0, 1, 0, 1, 2'd3));
`else
        check("ten_frames_no_timer", exp_out(0, 0, 1, 0, 2'd3));
`endif

        // Asynchronous reset mid-game
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check("pre_reset_lives2", exp_out(0, 0, 1, 0, 2'd2));
        #2 rst_n = 1'b0;
        #1 check("async_reset_clears", exp_out(0, 0, 0, 0, 2'd0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(0, 0, 1, 0, 0);
        check("post_reset_hit_ignored", exp_out(0, 0, 0, 0, 2'd0));
        step(0, 0, 0, 1, 1);
        check("post_reset_quiet", exp_out(0, 0, 0, 0, 2'd0));
        step(0, 1, 0, 0, 0);
        check("post_reset_start", exp_out(0, 0, 1, 0, 2'd3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
